puf_meas_ctrl: RTL and testbench
================================

# puf_meas_ctrl

Measurement controller for the ring-oscillator PUF: the initiator and reader on the edge-counter interface. On each request it clears a pair of edge counters and enables them for a fixed window of system-clock cycles. It then waits for the counters to settle, reads and compares both counts, and returns one response bit over a valid/ready handshake. It sits between the challenge/response front end and the two selected oscillator counters.

## Interface
- `NUM_BITS`, 32: counter width; width of `count_a`/`count_b`.
- `WINDOW_CYCLES`, 1024: cycles `cnt_en` is held high per measurement; must be ≥1.
- `CLEAR_CYCLES`, 4: cycles `cnt_clr` is held high before the window; must be ≥1.
- `SETTLE_CYCLES`, 8: cycles after the window before counts are sampled; must be ≥2.
- `clk` in 1: system clock; the only clock in the block.
- `arst` in 1: reset; **synchronous, active-high**, sampled on `clk`.
- `start_valid` in 1: measurement request.
- `start_ready` out 1: high only in IDLE.
- `cnt_clr` out 1: drives counter `arst` (clears counters).
- `cnt_en` out 1: drives counter `enable`.
- `count_a` in NUM_BITS: count from oscillator A.
- `count_b` in NUM_BITS: count from oscillator B.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts response.
- `resp_bit` out 1: 1 iff `count_a > count_b` (unsigned).
- `resp_tie` out 1: 1 iff `count_a == count_b`.
- `resp_diff` out NUM_BITS: |count_a − count_b|. Present only with `PUF_MEAS_DIFF_EN`.

## Operation
- States: IDLE → CLEAR → MEASURE → SETTLE → COMPARE → HOLD → IDLE.
- IDLE: `start_ready`=1. `start_valid`&&`start_ready` at an edge moves the block to CLEAR.
- CLEAR: `cnt_clr`=1 for exactly CLEAR_CYCLES cycles, then MEASURE.
- MEASURE: `cnt_en`=1 for exactly WINDOW_CYCLES cycles, then SETTLE.
- SETTLE: both strobes low for SETTLE_CYCLES cycles. Counters run on their own oscillator clocks; they are frozen here, so no synchronizer is needed on the count buses.
- COMPARE: one cycle. Registers `resp_bit`, `resp_tie` and `resp_diff` from `count_a`/`count_b`, then HOLD.
- HOLD: `resp_valid`=1 with outputs stable. `resp_valid`&&`resp_ready` at an edge returns the block to IDLE.
- Arithmetic: unsigned compare. `resp_diff` is computed in NUM_BITS+1 bits and the magnitude is taken as NUM_BITS. Counter wrap within a window is not detected; the integrator sizes NUM_BITS accordingly.
- Tie: `resp_bit`=0 and `resp_tie`=1.
- `start_valid` outside IDLE is ignored (not queued). `resp_ready` outside HOLD is ignored.
- Response outputs hold their last value until the next COMPARE.
- Reset mid-operation: the next edge with `arst`=1 forces IDLE and drops `cnt_en`, `cnt_clr` and `resp_valid`. Counters are not cleared by reset; the next request's CLEAR does that.

## Timing
- Reset values: `start_ready`=1; `cnt_clr`, `cnt_en`, `resp_valid`, `resp_bit` and `resp_tie`=0; `resp_diff`=0.
- All outputs are registered (state-decoded from registers); no combinational input→output path.
- Accept at edge T:
  - `cnt_clr` high for cycles T+1 … T+CLEAR_CYCLES.
  - `cnt_en` high for the next WINDOW_CYCLES cycles.
  - `resp_valid` first high at cycle T+CLEAR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+2.
- Back-to-back: with `resp_ready` held high, HOLD lasts 1 cycle. The next accept can occur on the edge after return to IDLE, so minimum period = latency + 2 cycles.

## Configuration
- `PUF_MEAS_DIFF_EN` defined:
  - `resp_diff` port and its subtractor/abs logic are built.
  - Registered in COMPARE; used for reliability/margin characterisation.
- Undefined:
  - Port absent; no subtractor logic.
  - All other behaviour identical.

## Structure
- Package `puf_meas_pkg`:
  - `meas_state_t` enum (IDLE, CLEAR, MEASURE, SETTLE, COMPARE, HOLD).
  - Timer-width function `$clog2(max(CLEAR,WINDOW,SETTLE)+1)`.
- Sub-module `puf_meas_timer`: loadable down-counter with a `load`/`value`/`done` interface. The FSM loads it with the length of each timed state and advances on `done`.

## Test plan
Bench params: WINDOW_CYCLES=16, CLEAR_CYCLES=2, SETTLE_CYCLES=4, NUM_BITS=16, `resp_ready`=1 unless stated.
- **Basic compare:** count_a=500, count_b=480 → `resp_bit`=1, `resp_tie`=0, `resp_diff`=20. `resp_valid` exactly 24 cycles after accept.
- **Strobe widths:** single start → `cnt_clr` high exactly 2 cycles, then `cnt_en` exactly 16 cycles, with no overlap and no gap.
- **Tie and reverse:** a=b=300 → `resp_bit`=0, `resp_tie`=1. a=10, b=65535 → `resp_bit`=0, `resp_diff`=65525.
- **Backpressure:** `resp_ready`=0 for 10 cycles → `resp_valid` and outputs stable and `start_ready`=0 throughout; `start_valid` pulses in that interval are ignored. Release → IDLE on the next edge.
- **Reset mid-MEASURE:** assert `arst` at window cycle 8 → `cnt_en`=0 and `start_ready`=1 after that edge; no `resp_valid`. A new start then completes normally.
- **Back-to-back:** `start_valid` held high for 3 measurements → 3 responses, accepts spaced exactly 26 cycles apart.

Source files
------------

// File: rtl/puf_meas_pkg.sv
// Shared types and helpers for the ring-oscillator PUF measurement controller.
// Build option: define PUF_MEAS_DIFF_EN to add the |count_a - count_b| output.
package puf_meas_pkg;

  // Measurement sequence, in the order the controller walks through it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    MEASURE = 3'd2,
    SETTLE  = 3'd3,
    COMPARE = 3'd4,
    HOLD    = 3'd5
  } meas_state_t;

  // Width of the shared phase timer.
  // It must be able to hold the longest phase length loaded into it.
  function automatic int timer_width(input int clear_cycles,
                                     input int window_cycles,
                                     input int settle_cycles);
    int longest;
    longest = clear_cycles;
    if (window_cycles > longest) longest = window_cycles;
    if (settle_cycles > longest) longest = settle_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/puf_meas_timer.sv
// Loadable down-counter used to time the CLEAR, MEASURE and SETTLE phases.
// A load of N raises done on the Nth cycle after the load edge.
// That is the last cycle of the phase, so the FSM can move on at that edge.
module puf_meas_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count down from the loaded value and stop at zero.
  always_ff @(posedge clk) begin
    if (arst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/puf_meas_ctrl.sv
// Ring-oscillator PUF measurement controller.
// Each request does the following:
//   - clears the selected edge-counter pair;
//   - enables the counters for a fixed window;
//   - lets them settle;
//   - compares the two counts;
//   - offers one response bit on a valid/ready handshake.
// Build option: define PUF_MEAS_DIFF_EN to add the registered resp_diff output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; start_ready high from the 2nd IDLE cycle on
// CLEAR   | cnt_clr high for CLEAR_CYCLES
// MEASURE | cnt_en high for WINDOW_CYCLES
// SETTLE  | both strobes low for SETTLE_CYCLES, count buses freeze
// COMPARE | one cycle, response registers load from count_a/count_b
// HOLD    | resp_valid high until resp_ready
module puf_meas_ctrl
  import puf_meas_pkg::*;
#(
  parameter int NUM_BITS      = 32,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                start_valid,
  output logic                start_ready,
  output logic                cnt_clr,
  output logic                cnt_en,
  input  logic [NUM_BITS-1:0] count_a,
  input  logic [NUM_BITS-1:0] count_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_bit,
  output logic                resp_tie
`ifdef PUF_MEAS_DIFF_EN
  ,
  output logic [NUM_BITS-1:0] resp_diff
`endif
);

  localparam int TW = timer_width(CLEAR_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES);

  meas_state_t   state;
  logic          accept;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  assign accept = start_valid && start_ready;

  // Load the timer with the length of the phase being entered.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          tmr_load  = 1'b1;
          tmr_value = TW'(CLEAR_CYCLES);
        end
      end
      CLEAR: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = TW'(WINDOW_CYCLES);
        end
      end
      MEASURE: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = TW'(SETTLE_CYCLES);
        end
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  puf_meas_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk  (clk),
    .arst (arst),
    .load (tmr_load),
    .value(tmr_value),
    .done (tmr_done)
  );

  // Sequencer with all handshake and strobe outputs registered.
  // After a response is taken, start_ready comes back one cycle later than
  // the return to IDLE. IDLE therefore always lasts at least one full cycle,
  // and back-to-back requests are spaced latency + 2 cycles apart.
  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      cnt_clr     <= 1'b0;
      cnt_en      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_bit    <= 1'b0;
      resp_tie    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= CLEAR;
            start_ready <= 1'b0;
            cnt_clr     <= 1'b1;
          end else begin
            start_ready <= 1'b1;
          end
        end
        CLEAR: begin
          if (tmr_done) begin
            state   <= MEASURE;
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b1;
          end
        end
        MEASURE: begin
          if (tmr_done) begin
            state  <= SETTLE;
            cnt_en <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_done) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          state      <= HOLD;
          resp_bit   <= (count_a > count_b);
          resp_tie   <= (count_a == count_b);
          resp_valid <= 1'b1;
        end
        HOLD: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          cnt_clr     <= 1'b0;
          cnt_en      <= 1'b0;
          resp_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PUF_MEAS_DIFF_EN
  logic [NUM_BITS:0]   diff_ext;
  logic [NUM_BITS:0]   diff_neg;
  logic [NUM_BITS-1:0] diff_mag;

  // Zero-extended subtraction.
  // The top bit is the borrow, which tells us which count was larger.
  assign diff_ext = {1'b0, count_a} - {1'b0, count_b};
  assign diff_neg = -diff_ext;
  assign diff_mag = diff_ext[NUM_BITS] ? diff_neg[NUM_BITS-1:0] : diff_ext[NUM_BITS-1:0];

  // Margin output, captured alongside resp_bit.
  always_ff @(posedge clk) begin
    if (arst) begin
      resp_diff <= '0;
    end else if (state == COMPARE) begin
      resp_diff <= diff_mag;
    end
  end
`endif

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Self-checking bench for puf_meas_ctrl using a timeline reference model.
module tb_puf_meas_ctrl;

  localparam int NB  = 16;
  localparam int WIN = 16;
  localparam int CLR = 2;
  localparam int SET = 4;
  localparam int CMP_PH = CLR + WIN + SET;

  logic          clk = 1'b0;
  logic          arst;
  logic          start_valid;
  logic          start_ready;
  logic          cnt_clr;
  logic          cnt_en;
  logic [NB-1:0] count_a;
  logic [NB-1:0] count_b;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_bit;
  logic          resp_tie;
`ifdef PUF_MEAS_DIFF_EN
  logic [NB-1:0] resp_diff;
`endif

  always #5 clk = ~clk;

  puf_meas_ctrl #(
    .NUM_BITS     (NB),
    .WINDOW_CYCLES(WIN),
    .CLEAR_CYCLES (CLR),
    .SETTLE_CYCLES(SET)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .cnt_clr    (cnt_clr),
    .cnt_en     (cnt_en),
    .count_a    (count_a),
    .count_b    (count_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_bit   (resp_bit),
    .resp_tie   (resp_tie)
`ifdef PUF_MEAS_DIFF_EN
    ,
    .resp_diff  (resp_diff)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: the time since accept, plus the latched response.
  bit m_active     = 1'b0;
  int m_ph         = 0;
  int m_idle_since = -1;
  bit m_bit        = 1'b0;
  bit m_tie        = 1'b0;
  int m_diff       = 0;

  // Observation statistics, reset per directed test.
  int clr_hi, en_hi, ovl, clr_last, en_first, rv_first, rv_seen, dut_hs;
  int dut_acc_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    clr_hi = 0; en_hi = 0; ovl = 0; clr_last = -1; en_first = -1;
    rv_first = -1; rv_seen = 0; dut_hs = 0;
  endtask

  // One clock: update the model at the edge, then check every output.
  task automatic tick();
    bit acc, hs, m_sr;
    m_sr = !m_active && (cyc > m_idle_since);
    acc  = start_valid && m_sr;
    hs   = m_active && (m_ph > CMP_PH) && resp_ready;
    if (start_valid && start_ready && !arst) dut_acc_q.push_back(cyc + 1);
    if (resp_valid && resp_ready && !arst) dut_hs++;
    @(posedge clk);
    cyc++;
    if (arst) begin
      m_active = 1'b0; m_idle_since = cyc - 1;
      m_bit = 1'b0; m_tie = 1'b0; m_diff = 0;
    end else if (acc) begin
      m_active = 1'b1; m_ph = 0;
    end else if (m_active) begin
      if (hs) begin
        m_active = 1'b0; m_idle_since = cyc;
      end else begin
        if (m_ph == CMP_PH) begin
          m_bit  = (int'(count_a) > int'(count_b));
          m_tie  = (int'(count_a) == int'(count_b));
          m_diff = (int'(count_a) > int'(count_b)) ? int'(count_a) - int'(count_b)
                                                   : int'(count_b) - int'(count_a);
        end
        m_ph++;
      end
    end
    @(negedge clk);
    check_val("start_ready", 32'(start_ready), 32'(!m_active && (cyc > m_idle_since)));
    check_val("cnt_clr",     32'(cnt_clr),     32'(m_active && m_ph < CLR));
    check_val("cnt_en",      32'(cnt_en),      32'(m_active && m_ph >= CLR && m_ph < CLR + WIN));
    check_val("resp_valid",  32'(resp_valid),  32'(m_active && m_ph > CMP_PH));
    check_val("resp_bit",    32'(resp_bit),    32'(m_bit));
    check_val("resp_tie",    32'(resp_tie),    32'(m_tie));
`ifdef PUF_MEAS_DIFF_EN
    check_val("resp_diff",   32'(resp_diff),   32'(m_diff));
`endif
    if (cnt_clr) begin clr_hi++; clr_last = cyc; end
    if (cnt_en) begin en_hi++; if (en_first < 0) en_first = cyc; end
    if (cnt_clr && cnt_en) ovl++;
    if (resp_valid) begin rv_seen++; if (rv_first < 0) rv_first = cyc; end
  endtask

  // Issue one request and wait for the first cycle of resp_valid.
  task automatic start_and_wait(input int a, input int b);
    int n0, guard;
    count_a = NB'(a); count_b = NB'(b);
    clear_stats();
    n0 = dut_acc_q.size();
    start_valid = 1'b1;
    guard = 0;
    while (dut_acc_q.size() == n0 && guard < 40) begin tick(); guard++; end
    start_valid = 1'b0;
    check_val("accept_seen", 32'(dut_acc_q.size()), 32'(n0 + 1));
    guard = 0;
    while (rv_first < 0 && guard < 60) begin tick(); guard++; end
    check_val("resp_seen", 32'(rv_first >= 0), 32'(1));
  endtask

  task automatic directed(input string tag, input int a, input int b,
                          input bit exp_bit, input bit exp_tie, input int exp_diff);
    start_and_wait(a, b);
    check_val({tag, "_bit"}, 32'(resp_bit), 32'(exp_bit));
    check_val({tag, "_tie"}, 32'(resp_tie), 32'(exp_tie));
`ifdef PUF_MEAS_DIFF_EN
    check_val({tag, "_diff"}, 32'(resp_diff), 32'(exp_diff));
`else
    if (exp_diff < 0) $display("note: negative diff in %s", tag);
`endif
    // resp_valid is sampled high at the edge after rv_first.
    check_val({tag, "_latency"}, 32'(rv_first + 1 - dut_acc_q[$]), 32'(24));
    check_val({tag, "_clr_width"}, 32'(clr_hi), 32'(2));
    check_val({tag, "_en_width"},  32'(en_hi), 32'(16));
    check_val({tag, "_no_gap"},    32'(en_first - clr_last), 32'(1));
    check_val({tag, "_no_ovl"},    32'(ovl), 32'(0));
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    int held_bit, n0, guard, na;
    arst = 1'b1; start_valid = 1'b0; resp_ready = 1'b1;
    count_a = '0; count_b = '0;
    clear_stats();
    tick(); tick();
    check_val("rst_start_ready", 32'(start_ready), 32'(1));
    check_val("rst_resp_valid",  32'(resp_valid),  32'(0));
    arst = 1'b0;
    tick(); tick();

    // Directed values.
    directed("basic",   500, 480,   1'b1, 1'b0, 20);
    directed("tie",     300, 300,   1'b0, 1'b1, 0);
    directed("reverse", 10,  65535, 1'b0, 1'b0, 65525);

    // Backpressure: the response must hold and new starts must be ignored.
    resp_ready = 1'b0;
    start_and_wait(1234, 999);
    held_bit = int'(resp_bit);
    n0 = dut_acc_q.size();
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      tick();
      check_val("bp_valid", 32'(resp_valid), 32'(1));
      check_val("bp_sready", 32'(start_ready), 32'(0));
      check_val("bp_bit", 32'(resp_bit), 32'(held_bit));
    end
    check_val("bp_no_accept", 32'(dut_acc_q.size()), 32'(n0));
    start_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    check_val("bp_release", 32'(resp_valid), 32'(0));
    tick(); tick();

    // Reset in the middle of the measurement window.
    clear_stats();
    count_a = NB'(77); count_b = NB'(88);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    guard = 0;
    while (en_hi < 8 && guard < 40) begin tick(); guard++; end
    check_val("mid_window_reached", 32'(en_hi), 32'(8));
    arst = 1'b1;
    tick();
    arst = 1'b0;
    check_val("rst_mid_en", 32'(cnt_en), 32'(0));
    check_val("rst_mid_sready", 32'(start_ready), 32'(1));
    for (int i = 0; i < 30; i++) tick();
    check_val("rst_mid_no_resp", 32'(rv_seen), 32'(0));
    directed("after_rst", 40000, 39999, 1'b1, 1'b0, 1);

    // Back-to-back requests with start_valid held high.
    clear_stats();
    count_a = NB'(5); count_b = NB'(6);
    n0 = dut_acc_q.size();
    start_valid = 1'b1;
    guard = 0;
    while (dut_acc_q.size() < n0 + 3 && guard < 200) begin tick(); guard++; end
    start_valid = 1'b0;
    guard = 0;
    while (dut_hs < 3 && guard < 60) begin tick(); guard++; end
    check_val("b2b_accepts", 32'(dut_acc_q.size() - n0), 32'(3));
    check_val("b2b_responses", 32'(dut_hs), 32'(3));
    na = dut_acc_q.size();
    if (na >= n0 + 3) begin
      check_val("b2b_space1", 32'(dut_acc_q[n0 + 1] - dut_acc_q[n0]), 32'(26));
      check_val("b2b_space2", 32'(dut_acc_q[n0 + 2] - dut_acc_q[n0 + 1]), 32'(26));
    end
    tick(); tick();

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      start_valid = ($urandom_range(0, 3) != 0);
      resp_ready  = ($urandom_range(0, 9) < 6);
      arst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        count_a = NB'($urandom);
        count_b = ($urandom_range(0, 4) == 0) ? count_a : NB'($urandom);
      end
      tick();
    end
    arst = 1'b0; start_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
